// File: rtl/spi_reg_bank.sv
// SPI Mode 0 write-only target loading the PWM peripheral control registers.
// SCLK/COPI/nCS are synchronized into clk and oversampled; 16-bit frames, MSB first.
module spi_reg_bank #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_done,
    output logic       txn_err
);

    localparam int unsigned NumRegs = 5;
    localparam int unsigned FlushW  = $clog2(SYNC_STAGES + 1);
    localparam logic [6:0]  MaxAddr = 7'(MAX_ADDR);
    localparam logic [4:0]  CntSat  = 5'd17;

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic                   sclk_q, sclk_d;
    logic                   ncs_q, ncs_d;
    logic [FlushW-1:0]      flush_q, flush_d;
    logic                   armed_q, armed_d;
    state_e                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [15:0]            sr_q, sr_d;
    logic [7:0]             regs_q [NumRegs];
    logic [7:0]             regs_d [NumRegs];
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_fall, ncs_rise;
    logic flush_done;
    logic [6:0] addr;

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s     = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s      = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_q;
    assign ncs_fall   = ~ncs_s & ncs_q;
    assign ncs_rise   = ncs_s & ~ncs_q;
    assign flush_done = (flush_q == FlushW'(SYNC_STAGES));
    assign addr       = sr_q[14:8];

    // The chains reset to idle levels, so a select held low across reset would look like a
    // fresh falling edge; frames are only accepted once nCS has been seen high from the pin.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        sclk_d      = sclk_s;
        ncs_d       = ncs_s;
        flush_d     = flush_done ? flush_q : flush_q + 1'b1;
        armed_d     = armed_q | (flush_done & ncs_s);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        regs_d  = regs_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ncs_fall && armed_q) begin
                    cnt_d   = '0;
                    sr_d    = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (ncs_rise) begin
                    state_d = StCommit;
                end else if (sclk_rise && !ncs_s) begin
                    sr_d = {sr_q[14:0], copi_s};
                    if (cnt_q != CntSat) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (cnt_q == 5'd16 && sr_q[15] && addr <= MaxAddr) begin
                    for (int i = 0; i < NumRegs; i++) begin
                        if (addr == 7'(i)) begin
                            regs_d[i] = sr_q[7:0];
                        end
                    end
                    done_d = 1'b1;
                end else if (!(cnt_q == 5'd16 && !sr_q[15])) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_q      <= 1'b0;
            ncs_q       <= 1'b1;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            sr_q        <= '0;
            regs_q      <= '{default: '0};
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_q      <= sclk_d;
            ncs_q       <= ncs_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            regs_q      <= regs_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign txn_done        = done_q;
    assign txn_err         = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: frames push expected pulses, a monitor pops and checks.
module tb_spi_reg_bank;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned MAX_ADDR    = 4;
    localparam int KNone = 0, KDone = 1, KErr = 2;

    typedef struct {
        int          kind;
        longint      cyc;
        logic [39:0] regs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       txn_done, txn_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      cyc = 0;
    logic [39:0] mdl = '0;
    exp_t        q[$];

    spi_reg_bank #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .txn_done        (txn_done),
        .txn_err         (txn_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Clock out n bits of v, MSB first; each SCLK phase is 4 clk periods.
    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] v, input int n, input int kind, input int gap);
        exp_t e;
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(v, n);
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        if (kind == KDone) mdl[v[10:8]*8 +: 8] = v[7:0];
        if (kind != KNone) begin
            e.kind = kind;
            e.cyc  = cyc + SYNC_STAGES + 2;
            e.regs = mdl;
            q.push_back(e);
        end
        repeat (gap) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (txn_done || txn_err) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {62'd0, txn_err, txn_done}, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", {62'd0, txn_err, txn_done}, 64'(e.kind));
                    check("pulse_latency", 64'(cyc), 64'(e.cyc));
                    check("pulse_regs", {24'd0, dut_regs()}, {24'd0, e.regs});
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset held with random pin activity.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sclk = 1'($urandom);
            copi = 1'($urandom);
            ncs  = 1'($urandom);
            if (i % 2 == 1) begin
                check("reset_regs", {24'd0, dut_regs()}, 64'd0);
                check("reset_pulses", {62'd0, txn_err, txn_done}, 64'd0);
            end
        end
        sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (8) @(negedge clk);

        // A write to every address.
        frame(32'h80F0, 16, KDone, 8);
        frame(32'h81AA, 16, KDone, 8);
        frame(32'h8255, 16, KDone, 8);
        frame(32'h830F, 16, KDone, 8);
        frame(32'h8480, 16, KDone, 8);
        check("all_writes", {24'd0, dut_regs()}, {24'd0, 40'h80_0F_55_AA_F0});

        // Asynchronous reset between edges clears outputs before the next edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_regs", {24'd0, dut_regs()}, 64'd0);
        mdl = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Read is dropped silently, bad address errors.
        frame(32'h8433, 16, KDone, 8);
        frame(32'h0412, 16, KNone, 8);
        check("read_ignored", {24'd0, dut_regs()}, {24'd0, mdl});
        frame(32'h85FF, 16, KErr, 8);
        check("bad_addr_kept", 64'(pwm_duty_cycle), 64'h33);

        // Short and overlong frames.
        frame(32'h8011, 16, KDone, 8);
        frame(32'h4019, 15, KErr, 8);
        frame(32'h10044, 17, KErr, 8);
        check("length_err_kept", 64'(en_reg_out_7_0), 64'h11);

        // Reset after 9 bits with nCS low; the remainder of the frame must be ignored.
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(32'h84C3 >> 7, 9);
        rst = 1'b1;
        mdl = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        shift_bits(32'h43, 7);
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (10) @(negedge clk);
        check("midframe_reset_regs", {24'd0, dut_regs()}, 64'd0);
        frame(32'h84C3, 16, KDone, 8);
        check("after_reset_write", 64'(pwm_duty_cycle), 64'hC3);

        // Back-to-back frames with minimum nCS-high gap.
        frame(32'h8201, 16, KDone, SYNC_STAGES + 2);
        frame(32'h8202, 16, KDone, 8);
        check("back_to_back", 64'(en_reg_pwm_7_0), 64'h02);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        check("final_regs", {24'd0, dut_regs()}, {24'd0, mdl});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
